// File: rtl/slave_bus_pkg.sv
// Shared types and register-map base addresses for the slave register bus initiator.
package slave_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead
  } state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        last;
  } rsp_entry_t;

  localparam logic [31:0] AddrFifo        = 32'h0000_0000;
  localparam logic [31:0] AddrDriverCntrl = 32'h0000_0004;
  localparam logic [31:0] AddrTraceAddr   = 32'h0000_0200;
  localparam logic [31:0] AddrTraceData   = 32'h0000_0210;
  localparam logic [31:0] AddrMonWin0     = 32'h0001_1000;
  localparam logic [31:0] AddrMonWin1     = 32'h0001_2000;
  localparam logic [31:0] AddrMonWin2     = 32'h0001_3000;
  localparam logic [31:0] AddrMonWin3     = 32'h0001_4000;

endpackage

// File: rtl/slave_bus_rsp_fifo.sv
// Synchronous response FIFO (power-of-two depth) with occupancy count.
module slave_bus_rsp_fifo
  import slave_bus_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  rsp_entry_t      wdata_i,
  input  logic            pop_i,
  output rsp_entry_t      rdata_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  rsp_entry_t      mem_q [Depth];
  logic            full;

  assign full    = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_i) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      // Credit accounting upstream must keep this from ever firing.
      assert (!(push_i && full && !pop_i));
    end
  end

endmodule

// File: rtl/slave_bus_master.sv
// Register-bus initiator: stream commands in, single-cycle rd/wr strobes out, read data back.
// Optional multi-beat bursts via `define SLAVE_BUS_MASTER_BURST_EN.
module slave_bus_master
  import slave_bus_pkg::*;
#(
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [7:0]  cmd_len_i,
  output logic [31:0] slave_addr_o,
  output logic        slave_rd_o,
  output logic        slave_wr_o,
  output logic [31:0] slave_data_in_o,
  input  logic [31:0] slave_data_out_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_last_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [31:0]     cur_addr_q, cur_addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     addr_hold_q, data_hold_q;
  logic            rd, wr, advance, beat_last, has_credit;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_last_q;
  logic [CntW-1:0] fifo_count, inflight;
  logic            fifo_empty, fifo_push, fifo_pop;
  rsp_entry_t      push_entry, pop_entry;

`ifdef SLAVE_BUS_MASTER_BURST_EN
  logic [7:0] beats_q, beats_d;
  assign beat_last = (beats_q == 8'd0);
`else
  logic unused_len;
  assign unused_len = ^cmd_len_i;
  assign beat_last  = 1'b1;
`endif

  assign inflight   = CntW'($countones(pipe_vld_q));
  // Reserve a FIFO slot for every read strobe before issuing it.
  assign has_credit = (32'(fifo_count) + 32'(inflight)) < RSP_DEPTH;
  assign cmd_ready_o = reset_ni && (state_q == StIdle);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    wdata_d    = wdata_q;
`ifdef SLAVE_BUS_MASTER_BURST_EN
    beats_d    = beats_q;
`endif
    rd         = 1'b0;
    wr         = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cur_addr_d = cmd_addr_i;
          wdata_d    = cmd_wdata_i;
`ifdef SLAVE_BUS_MASTER_BURST_EN
          beats_d    = cmd_len_i;
`endif
          state_d    = cmd_write_i ? StWrite : StRead;
        end
      end
      StWrite: begin
        wr      = 1'b1;
        advance = 1'b1;
      end
      StRead: begin
        rd      = has_credit;
        advance = has_credit;
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      cur_addr_d = cur_addr_q + ADDR_STRIDE;
      if (beat_last) state_d = StIdle;
`ifdef SLAVE_BUS_MASTER_BURST_EN
      else beats_d = beats_q - 8'd1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      wdata_q     <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
`ifdef SLAVE_BUS_MASTER_BURST_EN
      beats_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      wdata_q        <= wdata_d;
      addr_hold_q    <= slave_addr_o;
      data_hold_q    <= slave_data_in_o;
      pipe_vld_q[0]  <= rd;
      pipe_last_q[0] <= beat_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
`ifdef SLAVE_BUS_MASTER_BURST_EN
      beats_q        <= beats_d;
`endif
    end
  end

  // A stalled read shows the pending beat address; otherwise the bus holds its last value.
  assign slave_addr_o    = (state_q != StIdle) ? cur_addr_q : addr_hold_q;
  assign slave_data_in_o = (state_q == StWrite) ? wdata_q : data_hold_q;
  assign slave_rd_o      = rd;
  assign slave_wr_o      = wr;

  assign fifo_push  = pipe_vld_q[RD_LATENCY-1];
  assign push_entry = '{rdata: slave_data_out_i, last: pipe_last_q[RD_LATENCY-1]};
  assign fifo_pop   = !fifo_empty && rsp_ready_i;

  slave_bus_rsp_fifo #(
    .Depth(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (reset_ni),
    .push_i (fifo_push),
    .wdata_i(push_entry),
    .pop_i  (fifo_pop),
    .rdata_o(pop_entry),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = pop_entry.rdata;
  assign rsp_last_o  = pop_entry.last;
  assign busy_o      = (state_q != StIdle) || (|pipe_vld_q) || !fifo_empty;

endmodule

// File: tb/tb_slave_bus_master.sv
// Bench for slave_bus_master: directed timing steps plus random traffic against a queue model.
module tb_slave_bus_master;
  import slave_bus_pkg::*;

  localparam int unsigned RdLat  = 1;
  localparam int unsigned Depth  = 4;
  localparam int unsigned Stride = 4;
`ifdef SLAVE_BUS_MASTER_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_len;
  logic [31:0] slave_addr, slave_data_in, slave_data_out;
  logic        slave_rd, slave_wr;
  logic        rsp_valid, rsp_last, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  int ready_mode = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [31:0] d; logic l;} rsp_t;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  rsp_t        exp_rsp[$];

  always #5 clk = ~clk;

  slave_bus_master #(
    .RD_LATENCY (RdLat),
    .RSP_DEPTH  (Depth),
    .ADDR_STRIDE(Stride)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (rst_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_write_i     (cmd_write),
    .cmd_addr_i      (cmd_addr),
    .cmd_wdata_i     (cmd_wdata),
    .cmd_len_i       (cmd_len),
    .slave_addr_o    (slave_addr),
    .slave_rd_o      (slave_rd),
    .slave_wr_o      (slave_wr),
    .slave_data_in_o (slave_data_in),
    .slave_data_out_i(slave_data_out),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_last_o      (rsp_last),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Slave register contents: fixed per address, 0x104 returns 0x55.
  function automatic logic [31:0] sval(input logic [31:0] a);
    return (a == 32'h104) ? 32'h55 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  function automatic int unsigned nbeats(input logic [7:0] len);
    return Burst ? 32'(len) + 32'd1 : 32'd1;
  endfunction

  logic [31:0] dpipe [RdLat];
  always @(posedge clk) begin
    dpipe[0] <= slave_rd ? sval(slave_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < RdLat; i++) dpipe[i] <= dpipe[i-1];
  end
  assign slave_data_out = dpipe[RdLat-1];

  always @(posedge clk) begin
    case (ready_mode)
      0:       rsp_ready <= 1'b0;
      1:       rsp_ready <= 1'b1;
      default: rsp_ready <= 1'($urandom_range(0, 1));
    endcase
  end

  wr_t  mw;
  rsp_t mr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (slave_rd || slave_wr) chk1("rd_wr_excl", slave_rd & slave_wr, 1'b0);
      if (slave_wr) begin
        if (exp_wr.size() == 0) chk1("wr_unexpected", slave_wr, 1'b0);
        else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", slave_addr, mw.addr);
          chk("wr_data", slave_data_in, mw.data);
        end
      end
      if (slave_rd) begin
        if (exp_rd.size() == 0) chk1("rd_unexpected", slave_rd, 1'b0);
        else chk("rd_addr", slave_addr, exp_rd.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) chk1("rsp_unexpected", rsp_valid, 1'b0);
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, mr.d);
          chk1("rsp_last", rsp_last, mr.l);
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [7:0] len);
    int unsigned n;
    int guard;
    logic [31:0] a;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_len   = len;
    guard = 0;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) chk1("cmd_accept_timeout", cmd_ready, 1'b1);
    n = nbeats(len);
    for (int unsigned k = 0; k < n; k++) begin
      a = addr + k * Stride;
      if (wr) exp_wr.push_back('{addr: a, data: data});
      else begin
        exp_rd.push_back(a);
        exp_rsp.push_back('{d: sval(a), l: (k == n - 1)});
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_rsp.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0 || busy)
           && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_pending_rsp"}, 32'(exp_rsp.size()), 32'h0);
    chk1({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0;
    int unsigned n, issued;
    logic [31:0] held;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_slave_rd", slave_rd, 1'b0);
    chk1("rst_slave_wr", slave_wr, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_slave_addr", slave_addr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    #1 chk1("rel_cmd_ready", cmd_ready, 1'b1);

    // Single write: strobe one cycle after acceptance, then idle.
    send(1'b1, AddrDriverCntrl, 32'h1, 8'd0);
    chk1("w1_wr", slave_wr, 1'b1);
    chk1("w1_rd", slave_rd, 1'b0);
    chk("w1_addr", slave_addr, 32'h4);
    chk("w1_data", slave_data_in, 32'h1);
    @(posedge clk); #1;
    chk1("w1_wr_after", slave_wr, 1'b0);
    chk1("w1_busy_after", busy, 1'b0);
    chk1("w1_no_rsp", rsp_valid, 1'b0);
    chk("w1_addr_hold", slave_addr, 32'h4);
    chk("w1_data_hold", slave_data_in, 32'h1);

    // Single read: response RD_LATENCY+1 cycles after the strobe.
    ready_mode = 1;
    @(posedge clk);
    send(1'b0, 32'h104, 32'h0, 8'd0);
    chk1("r1_rd", slave_rd, 1'b1);
    chk("r1_addr", slave_addr, 32'h104);
    repeat (RdLat) begin
      @(posedge clk); #1;
      chk1("r1_rsp_early", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    chk1("r1_rsp_valid", rsp_valid, 1'b1);
    chk("r1_rsp_rdata", rsp_rdata, 32'h55);
    chk1("r1_rsp_last", rsp_last, 1'b1);
    drain("r1");

    // Burst read with a free-running consumer: back-to-back strobes.
    r0 = rsp_seen;
    n = nbeats(8'd7);
    send(1'b0, AddrTraceData, 32'h0, 8'd7);
    for (int unsigned k = 0; k < n; k++) begin
      chk1("b8_rd", slave_rd, 1'b1);
      chk("b8_addr", slave_addr, AddrTraceData + k * Stride);
      @(posedge clk); #1;
    end
    chk1("b8_rd_end", slave_rd, 1'b0);
    drain("b8");
    chk("b8_count", 32'(rsp_seen - r0), n);

    // Burst read with a stalled consumer: credits cap the strobes at the FIFO depth.
    ready_mode = 0;
    @(posedge clk);
    r0 = rsp_seen;
    send(1'b0, AddrTraceData, 32'h0, 8'd7);
    issued = (n > Depth) ? Depth : n;
    held = (n > Depth) ? AddrTraceData + Stride * Depth : AddrTraceData + Stride * (n - 1);
    for (int unsigned k = 0; k < issued; k++) begin
      chk1("st_rd", slave_rd, 1'b1);
      chk("st_addr", slave_addr, AddrTraceData + k * Stride);
      @(posedge clk); #1;
    end
    repeat (6) begin
      chk1("st_rd_stall", slave_rd, 1'b0);
      chk("st_addr_hold", slave_addr, held);
      chk1("st_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    ready_mode = 1;
    drain("st");
    chk("st_count", 32'(rsp_seen - r0), n);

    // Reset during beat 3 of a burst read.
    send(1'b0, AddrMonWin0, 32'h0, 8'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_rd.delete();
    exp_rsp.delete();
    exp_wr.delete();
    @(posedge clk); #1;
    chk1("mr_rd", slave_rd, 1'b0);
    chk1("mr_rsp_valid", rsp_valid, 1'b0);
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_cmd_ready", cmd_ready, 1'b0);
    chk("mr_addr", slave_addr, 32'h0);
    rst_n = 1'b1;
    #1 chk1("mr_rel_cmd_ready", cmd_ready, 1'b1);
    r0 = rsp_seen;
    repeat (8) begin
      @(posedge clk); #1;
      chk1("mr_stale_rsp", rsp_valid, 1'b0);
      chk1("mr_stale_rd", slave_rd, 1'b0);
    end
    chk("mr_no_rsp", 32'(rsp_seen - r0), 32'h0);

    // Address wrap at the top of the 32-bit space.
    n = nbeats(8'd1);
    send(1'b0, 32'hFFFF_FFFC, 32'h0, 8'd1);
    chk1("wrap_rd0", slave_rd, 1'b1);
    chk("wrap_addr0", slave_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk1("wrap_rd1", slave_rd, n > 1);
    chk("wrap_addr1", slave_addr, (n > 1) ? 32'h0 : 32'hFFFF_FFFC);
    drain("wrap");

    // Random mix of reads and writes with a randomly stalling consumer.
    ready_mode = 2;
    repeat (40) begin
      send(1'($urandom_range(0, 1)), AddrMonWin1 + 32'($urandom_range(0, 63)) * 32'd4,
           $urandom, 8'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
